mxu_seq_ctrl: RTL and testbench

MXU_SEQ_CTRL -- requirements
Module: mxu_seq_ctrl

---
 rtl/mxu_seq_ctrl_pkg.sv | 46 ++++
 rtl/mxu_token_pipe.sv | 51 +++++
 rtl/mxu_seq_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_mxu_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxu_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mxu_seq_ctrl_pkg
//   Shared definitions for the MXU sequencing controller:
//     - precision select width and encodings driven onto the MAC array
//     - default token-pipe latency of the MAC array
//     - sequencer state encoding
//     - latched per-job configuration record
//   No ports; imported by mxu_seq_ctrl and mxu_token_pipe.
// -----------------------------------------------------------------------------
`ifndef LOG_ALLOWED_PRECISIONS
`define LOG_ALLOWED_PRECISIONS 2
`endif

package mxu_seq_ctrl_pkg;

    // Width of the precision select carried on cfg_data_type / data_type.
    localparam int LOG_ALLOWED_PRECISIONS = `LOG_ALLOWED_PRECISIONS;

    // Precision encodings understood by the MAC array.
    typedef enum logic [1:0] {
        PREC_INT8  = 2'd0,
        PREC_INT16 = 2'd1,
        PREC_FP16  = 2'd2,
        PREC_BF16  = 2'd3
    } precision_e;

    // ce-enabled cycles from input acceptance to result at the array output.
    localparam int PIPE_LAT_DEFAULT = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LOAD_W = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Configuration captured on job start and held for the whole job.
    typedef struct packed {
        logic [LOG_ALLOWED_PRECISIONS-1:0] data_type;
        logic [1:0]                        fp;
        logic                              chain;
    } job_cfg_t;

endpackage

// File: rtl/mxu_token_pipe.sv
// -----------------------------------------------------------------------------
// mxu_token_pipe
//   Shadow of the MAC array pipeline: a DEPTH-deep shift register of 1-bit
//   tokens, one token per accepted input vector. It moves only when the
//   array clock enable moves, so the token reaching the last stage marks the
//   cycle the matching result is at the array output.
//
//   Ports
//     clk    in   clock
//     reset  in   asynchronous active-low clear of all stages
//     adv    in   shift enable (the array ce)
//     din    in   token entering stage 0 on an advancing cycle
//     dout   out  last stage (result valid at the array output)
//     empty  out  no token will remain once this cycle's update is applied
// -----------------------------------------------------------------------------
module mxu_token_pipe
    import mxu_seq_ctrl_pkg::*;
#(
    parameter int DEPTH = PIPE_LAT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic adv,
    input  logic din,
    output logic dout,
    output logic empty
);

    logic [DEPTH-1:0] stages_q;
    logic [DEPTH-1:0] stages_d;

    // The outgoing last stage falls off the top of the shift.
    assign stages_d = adv ? ((stages_q << 1) | DEPTH'(din)) : stages_q;

    // NOTE: the token stages are a shift register, not a memory; they are reset
    // because out_valid is taken straight from the last stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stages_q <= '0;
        end else begin
            stages_q <= stages_d;
        end
    end

    assign dout = stages_q[DEPTH-1];

    // Look-ahead so the sequencer can leave DRAIN on the same edge that
    // retires the final token.
    assign empty = ~|stages_d;

endmodule

// File: rtl/mxu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mxu_seq_ctrl
//   Job sequencer for one systolic MAC column. A job is:
//     CLEAR  (1 cycle, synchronous clear of the accumulators)
//     LOAD_W (ROWS cycles, one weight row per cycle)
//     STREAM (accept n_vectors input beats)
//     DRAIN  (wait until every result has left the array)
//     DONE   (1-cycle done pulse)
//   abort sends any running job through CLEAR back to IDLE without done.
//
//   Ports
//     clk, reset                    clock, asynchronous active-low reset
//     start, abort                  job launch / job kill
//     cfg_data_type, cfg_fp,
//     cfg_chain, n_vectors          job configuration, latched on start
//     in_valid / in_ready           input-vector handshake
//     out_valid / out_ready         result handshake
//     ce, sclr, enable_chain,
//     data_type, enable_fp_unit     MAC array controls
//     w_load, w_row                 weight-row load strobe and row index
//     busy, done                    job status
// -----------------------------------------------------------------------------
module mxu_seq_ctrl
    import mxu_seq_ctrl_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int PIPE_LAT = PIPE_LAT_DEFAULT,
    parameter int CNT_W    = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              abort,
    input  logic [LOG_ALLOWED_PRECISIONS-1:0] cfg_data_type,
    input  logic [1:0]                        cfg_fp,
    input  logic                              cfg_chain,
    input  logic [CNT_W-1:0]                  n_vectors,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              ce,
    output logic                              sclr,
    output logic                              enable_chain,
    output logic [LOG_ALLOWED_PRECISIONS-1:0] data_type,
    output logic [1:0]                        enable_fp_unit,
    output logic                              w_load,
    output logic [$clog2(ROWS)-1:0]           w_row,
    output logic                              busy,
    output logic                              done
);

    localparam int ROW_W = $clog2(ROWS);

    state_e            state_q, state_d;
    job_cfg_t          cfg_q;
    logic [CNT_W-1:0]  n_vec_q;
    logic [CNT_W-1:0]  vec_cnt_q;
    logic [ROW_W-1:0]  w_row_q;
    logic              aborting_q;
    logic              flush_q;

    logic              start_hit;
    logic              abort_hit;
    logic              stall;
    logic              accept;
    logic              last_vec;
    logic              last_row;
    logic              pipe_rst_n;
    logic              pipe_dout;
    logic              pipe_empty;

    // -------------------------------------------------------------------------
    // Shared decode
    // -------------------------------------------------------------------------
    assign start_hit = (state_q == ST_IDLE) & start & ~abort;
    assign abort_hit = (state_q != ST_IDLE) & abort;

    assign out_valid = pipe_dout;
    assign stall     = out_valid & ~out_ready;
    assign accept    = (state_q == ST_STREAM) & in_valid & ~stall;

    // vec_cnt_q never exceeds n_vec_q-1 while streaming, so +1 cannot wrap
    // even for the largest legal n_vectors.
    assign last_vec  = (vec_cnt_q + CNT_W'(1)) == n_vec_q;
    assign last_row  = w_row_q == ROW_W'(ROWS - 1);

    // -------------------------------------------------------------------------
    // State register and job bookkeeping
    // -------------------------------------------------------------------------
    // NOTE: every register here is written with <= so all of them sample the
    // same pre-edge values; a blocking write would leak into later reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            n_vec_q    <= '0;
            vec_cnt_q  <= '0;
            w_row_q    <= '0;
            aborting_q <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (start_hit) begin
                cfg_q.data_type <= cfg_data_type;
                cfg_q.fp        <= cfg_fp;
                cfg_q.chain     <= cfg_chain;
                n_vec_q         <= n_vectors;
            end

            if (start_hit || abort_hit) begin
                vec_cnt_q <= '0;
            end else if (accept) begin
                vec_cnt_q <= vec_cnt_q + CNT_W'(1);
            end

            if (state_q == ST_LOAD_W && state_d == ST_LOAD_W) begin
                w_row_q <= w_row_q + ROW_W'(1);
            end else begin
                w_row_q <= '0;
            end

            // Remembers that the coming CLEAR ends the job instead of
            // leading into LOAD_W.
            if (abort_hit) begin
                aborting_q <= 1'b1;
            end else if (state_q == ST_CLEAR) begin
                aborting_q <= 1'b0;
            end

            flush_q <= abort_hit;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (abort_hit) begin
            state_d = ST_CLEAR;
        end else begin
            case (state_q)
                ST_IDLE:   if (start_hit) state_d = ST_CLEAR;
                ST_CLEAR:  state_d = aborting_q ? ST_IDLE : ST_LOAD_W;
                ST_LOAD_W: begin
                    if (last_row) begin
                        state_d = (n_vec_q == '0) ? ST_DRAIN : ST_STREAM;
                    end
                end
                ST_STREAM: if (accept && last_vec) state_d = ST_DRAIN;
                ST_DRAIN:  if (pipe_empty) state_d = ST_DONE;
                ST_DONE:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        ce             = 1'b0;
        sclr           = 1'b0;
        in_ready       = 1'b0;
        w_load         = 1'b0;
        w_row          = '0;
        done           = 1'b0;
        busy           = (state_q != ST_IDLE);
        data_type      = '0;
        enable_fp_unit = '0;
        enable_chain   = 1'b0;

        if (busy) begin
            data_type      = cfg_q.data_type;
            enable_fp_unit = cfg_q.fp;
            enable_chain   = cfg_q.chain;
        end

        case (state_q)
            ST_CLEAR: begin
                ce   = 1'b1;
                sclr = 1'b1;
            end
            ST_LOAD_W: begin
                ce     = 1'b1;
                w_load = 1'b1;
                w_row  = w_row_q;
            end
            ST_STREAM: begin
                in_ready = ~stall;
                ce       = in_valid & ~stall;
            end
            ST_DRAIN: begin
                ce = ~stall;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Token pipe
    // -------------------------------------------------------------------------
    // An abort empties the pipe through its reset. flush_q is a flop output,
    // so the derived reset is glitch-free and releases on a clock edge.
    assign pipe_rst_n = reset & ~flush_q;

    mxu_token_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_token_pipe (
        .clk   (clk),
        .reset (pipe_rst_n),
        .adv   (ce),
        .din   (accept),
        .dout  (pipe_dout),
        .empty (pipe_empty)
    );

endmodule

// File: tb/tb_mxu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mxu_seq_ctrl
//   Directed bench for mxu_seq_ctrl with ROWS=4, PIPE_LAT=10, CNT_W=16.
//   Each job is described by per-cycle stimulus bit patterns (bit c applies
//   to cycle c, cycle 0 being the cycle start is presented). Outputs are
//   sampled on the falling edge and folded into per-cycle bit masks that
//   are compared against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_mxu_seq_ctrl;
    import mxu_seq_ctrl_pkg::*;

    localparam int ROWS     = 4;
    localparam int PIPE_LAT = 10;
    localparam int CNT_W    = 16;

    localparam logic [1:0] CFG_DT = 2'd2;
    localparam logic [1:0] CFG_FP = 2'b01;
    localparam logic       CFG_CH = 1'b1;

    logic                              clk;
    logic                              reset;
    logic                              start;
    logic                              abort;
    logic [LOG_ALLOWED_PRECISIONS-1:0] cfg_data_type;
    logic [1:0]                        cfg_fp;
    logic                              cfg_chain;
    logic [CNT_W-1:0]                  n_vectors;
    logic                              in_valid;
    logic                              in_ready;
    logic                              out_valid;
    logic                              out_ready;
    logic                              ce;
    logic                              sclr;
    logic                              enable_chain;
    logic [LOG_ALLOWED_PRECISIONS-1:0] data_type;
    logic [1:0]                        enable_fp_unit;
    logic                              w_load;
    logic [$clog2(ROWS)-1:0]           w_row;
    logic                              busy;
    logic                              done;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle observation masks of the last job.
    logic [31:0] acc_m, ov_m, hs_m, done_m, busy_m, ce_m, sclr_m, wl_m, ir_m;
    logic [1:0]  w_row_log [32];
    logic [4:0]  cfg_log   [32];

    mxu_seq_ctrl #(
        .ROWS     (ROWS),
        .PIPE_LAT (PIPE_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .cfg_data_type  (cfg_data_type),
        .cfg_fp         (cfg_fp),
        .cfg_chain      (cfg_chain),
        .n_vectors      (n_vectors),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .ce             (ce),
        .sclr           (sclr),
        .enable_chain   (enable_chain),
        .data_type      (data_type),
        .enable_fp_unit (enable_fp_unit),
        .w_load         (w_load),
        .w_row          (w_row),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] all_outs();
        return {busy, done, ce, sclr, in_ready, out_valid, w_load,
                w_row, data_type, enable_fp_unit, enable_chain};
    endfunction

    // Runs ncyc cycles starting at posedge+1. Configuration inputs carry the
    // job values only in cycle 0 and their complement afterwards, so any
    // output that follows the live inputs instead of the latched copy shows.
    task automatic run_job(input logic [CNT_W-1:0] nv, input logic [31:0] st_pat,
                           input logic [31:0] iv_pat, input logic [31:0] or_pat,
                           input logic [31:0] ab_pat, input int ncyc);
        acc_m = '0; ov_m = '0; hs_m = '0; done_m = '0; busy_m = '0;
        ce_m = '0; sclr_m = '0; wl_m = '0; ir_m = '0;
        n_vectors = nv;
        for (int c = 0; c < ncyc; c++) begin
            start     = st_pat[c];
            in_valid  = iv_pat[c];
            out_ready = or_pat[c];
            abort     = ab_pat[c];
            if (c == 0) begin
                cfg_data_type = CFG_DT;
                cfg_fp        = CFG_FP;
                cfg_chain     = CFG_CH;
            end else begin
                cfg_data_type = ~CFG_DT;
                cfg_fp        = ~CFG_FP;
                cfg_chain     = ~CFG_CH;
            end
            @(negedge clk);
            acc_m[c]     = in_valid & in_ready;
            ov_m[c]      = out_valid;
            hs_m[c]      = out_valid & out_ready;
            done_m[c]    = done;
            busy_m[c]    = busy;
            ce_m[c]      = ce;
            sclr_m[c]    = sclr;
            wl_m[c]      = w_load;
            ir_m[c]      = in_ready;
            w_row_log[c] = w_row;
            cfg_log[c]   = {data_type, enable_fp_unit, enable_chain};
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        abort     = 1'b0;
    endtask

    initial begin
        int acc_cnt;
        int out_cnt;
        int done_cyc;

        // ---------------- reset state, with busy-looking inputs applied
        reset         = 1'b0;
        start         = 1'b1;
        abort         = 1'b0;
        cfg_data_type = 2'd3;
        cfg_fp        = 2'b11;
        cfg_chain     = 1'b1;
        n_vectors     = 16'd5;
        in_valid      = 1'b1;
        out_ready     = 1'b0;
        #12;
        check("reset_outputs_zero", 64'(all_outs()), 64'h0);
        @(negedge clk);
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- basic job: n=3, free-flowing handshakes
        run_job(16'd3, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 24);
        check("a_sclr_cycle1",    64'(sclr_m), 64'h0000_0002);
        check("a_wload_cyc2_5",   64'(wl_m),   64'h0000_003C);
        for (int r = 0; r < ROWS; r++) begin
            check("a_w_row", 64'(w_row_log[2 + r]), 64'(r));
        end
        check("a_w_row_after",    64'(w_row_log[6]), 64'h0);
        check("a_accepts_6_8",    64'(acc_m),  64'h0000_01C0);
        check("a_out_valid_16_18",64'(ov_m),   64'h0007_0000);
        check("a_done_19",        64'(done_m), 64'h0008_0000);
        check("a_busy_1_19",      64'(busy_m), 64'h000F_FFFE);
        check("a_ce_1_18",        64'(ce_m),   64'h0007_FFFE);
        check("a_cfg_latched",    64'(cfg_log[4]),  64'({CFG_DT, CFG_FP, CFG_CH}));
        check("a_cfg_idle_zero",  64'(cfg_log[22]), 64'h0);

        // ---------------- n_vectors=0: LOAD_W straight to DRAIN, then DONE
        run_job(16'd0, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 12);
        check("b_accepts_none",   64'(acc_m),  64'h0);
        check("b_out_valid_none", 64'(ov_m),   64'h0);
        check("b_done_7",         64'(done_m), 64'h0000_0080);
        check("b_busy_1_7",       64'(busy_m), 64'h0000_00FE);
        check("b_ce_1_6",         64'(ce_m),   64'h0000_007E);

        // ---------------- output stall in cycles 16-20; start held 0-15
        run_job(16'd3, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'hFFE0_FFFF, 32'h0, 28);
        check("c_accepts_6_8",    64'(acc_m),  64'h0000_01C0);
        check("c_in_ready_6_8",   64'(ir_m),   64'h0000_01C0);
        check("c_out_valid_hold", 64'(ov_m),   64'h00FF_0000);
        check("c_ce_frozen",      64'(ce_m),   64'h00E0_FFFE);
        check("c_results_3",      64'($countones(hs_m)), 64'd3);
        check("c_done_24",        64'(done_m), 64'h0100_0000);
        check("c_busy_1_24",      64'(busy_m), 64'h01FF_FFFE);

        // ---------------- in_valid 1,0,1,0,1 from cycle 6; start also in DONE
        run_job(16'd3, 32'h0020_0001, 32'h0000_0540, 32'hFFFF_FFFF, 32'h0, 26);
        check("d_accepts_6_8_10", 64'(acc_m),  64'h0000_0540);
        check("d_ce_follows_iv",  64'(ce_m),   64'h001F_FD7E);
        check("d_out_valid",      64'(ov_m),   64'h001C_0000);
        check("d_done_21",        64'(done_m), 64'h0020_0000);
        check("d_busy_no_rerun",  64'(busy_m), 64'h003F_FFFE);

        // ---------------- abort in STREAM cycle 7
        run_job(16'd3, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0080, 20);
        check("e_accepts_6_7",    64'(acc_m),  64'h0000_00C0);
        check("e_sclr_1_8",       64'(sclr_m), 64'h0000_0102);
        check("e_busy_1_8",       64'(busy_m), 64'h0000_01FE);
        check("e_no_done",        64'(done_m), 64'h0);
        check("e_no_out_valid",   64'(ov_m),   64'h0);

        // ---------------- following job must see no stale tokens
        run_job(16'd1, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 20);
        check("e2_accept_6",      64'(acc_m),  64'h0000_0040);
        check("e2_out_valid_16",  64'(ov_m),   64'h0001_0000);
        check("e2_done_17",       64'(done_m), 64'h0002_0000);

        // ---------------- abort together with start in IDLE
        run_job(16'd3, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h1, 4);
        check("f_abort_start_idle", 64'(busy_m | sclr_m), 64'h0);

        // ---------------- reset in DRAIN, then a clean job
        run_job(16'd3, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 12);
        check("g_in_drain_busy",  64'({busy, in_ready, out_valid}), 64'b100);
        reset = 1'b0;
        #1;
        check("g_reset_outputs_zero", 64'(all_outs()), 64'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_job(16'd3, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 24);
        check("g_accepts_6_8",    64'(acc_m),  64'h0000_01C0);
        check("g_out_valid_16_18",64'(ov_m),   64'h0007_0000);
        check("g_done_19",        64'(done_m), 64'h0008_0000);

        // ---------------- largest legal job: n_vectors = 2^CNT_W-1
        n_vectors     = 16'hFFFF;
        cfg_data_type = CFG_DT;
        cfg_fp        = CFG_FP;
        cfg_chain     = CFG_CH;
        in_valid      = 1'b1;
        out_ready     = 1'b1;
        abort         = 1'b0;
        start         = 1'b1;
        acc_cnt       = 0;
        out_cnt       = 0;
        done_cyc      = -1;
        for (int c = 0; c < 70000 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc_cnt++;
            if (out_valid && out_ready) out_cnt++;
            if (done) done_cyc = c;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        check("h_max_accepts",    64'(acc_cnt),  64'd65535);
        check("h_max_results",    64'(out_cnt),  64'd65535);
        check("h_max_done_cycle", 64'(done_cyc), 64'd65551);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
